// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared definitions for the pipelined radix-4 Booth multiplier.
//   booth_digit_t  - radix-4 Booth digit {ZERO, POS1, POS2, NEG1, NEG2}
//   booth_encode() - maps the overlapping multiplier triple to a digit
//   npp()          - number of Booth partial products for a given width
//   csa_levels()   - number of 3:2 CSA levels to reduce the partial products
//                    plus the negate carry-in row down to two rows
package booth_mul_pkg;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    function automatic booth_digit_t booth_encode(input logic [2:0] bits);
        booth_digit_t d;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;   // 000 and 111 (-0 is treated as 0)
        endcase
        return d;
    endfunction

    // Operands are extended by two bits, so WIDTH+2 bits give WIDTH/2+1 digits.
    function automatic int unsigned npp(input int unsigned width);
        return width / 2 + 1;
    endfunction

    // The extra row is the packed vector of negate carry-ins.
    function automatic int unsigned csa_levels(input int unsigned n_pp);
        int unsigned rows;
        int unsigned lv;
        rows = n_pp + 1;
        lv   = 0;
        while (rows > 2) begin
            rows = rows - rows / 3;
            lv   = lv + 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/booth_mul_pipe_pp_gen.sv
// booth_pp_gen: one radix-4 Booth partial-product selector.
//   x    in  EW  extended multiplicand (sign- or zero-extended by two bits)
//   sel  in  3   multiplier triple {y[2i+1], y[2i], y[2i-1]}
//   pp   out EW  selected multiple, bit-inverted when the digit is negative
//   neg  out 1   carry-in that completes the two's complement negation
module booth_pp_gen
    import booth_mul_pkg::*;
#(
    parameter int unsigned EW = 34
) (
    input  logic [EW-1:0] x,
    input  logic [2:0]    sel,
    output logic [EW-1:0] pp,
    output logic          neg
);

    booth_digit_t digit;
    logic [EW-1:0] mag;

    always_comb begin
        digit = booth_encode(sel);
        mag   = '0;
        neg   = 1'b0;
        case (digit)
            POS1: mag = x;
            POS2: mag = {x[EW-2:0], 1'b0};
            NEG1: begin
                mag = x;
                neg = 1'b1;
            end
            NEG2: begin
                mag = {x[EW-2:0], 1'b0};
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        pp = neg ? ~mag : mag;
    end

endmodule

// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: pipelined radix-4 Booth / CSA-tree multiplier, full 2*WIDTH product.
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_signed, in_x, in_y sampled on transfer
//   out_valid/out_ready   product handshake; out_result held while stalled
//   in_tag/out_tag        sideband tag travelling with each beat, present only
//                         when BOOTH_MUL_TAG_EN is defined
// Parameters: WIDTH (even, 8..64), STAGES (1..4), TAG_W.
module booth_mul_pipe
    import booth_mul_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
`ifdef BOOTH_MUL_TAG_EN
    input  logic [TAG_W-1:0]     in_tag,
    output logic [TAG_W-1:0]     out_tag,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result
);

    localparam int unsigned EW   = WIDTH + 2;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned NPP  = npp(WIDTH);
    localparam int unsigned MAXR = NPP + 1;
    localparam int unsigned LV   = csa_levels(NPP);
    localparam logic [STAGES-1:0] ONES = '1;

    // Every pipeline stage carries the same row array; rows beyond the count
    // live at that CSA level are zero and trim away.
    typedef logic [MAXR-1:0][PW-1:0] rows_t;

    // Apply CSA levels lo..hi-1 to rows already at level lo.
    function automatic rows_t csa_reduce(input rows_t r, input int unsigned lo,
                                         input int unsigned hi);
        rows_t       cur;
        rows_t       nxt;
        int unsigned n;
        int unsigned g;
        cur = r;
        n   = MAXR;
        for (int unsigned l = 0; l < LV; l++) begin
            g = n / 3;
            if (l >= lo && l < hi) begin
                nxt = '0;
                for (int unsigned j = 0; j < MAXR / 3; j++) begin
                    if (j < g) begin
                        nxt[2*j]   = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
                        nxt[2*j+1] = ((cur[3*j] & cur[3*j+1]) | (cur[3*j] & cur[3*j+2]) |
                                      (cur[3*j+1] & cur[3*j+2])) << 1;
                    end
                end
                for (int unsigned j = 0; j < 2; j++) begin
                    if (j < n - 3 * g) nxt[2*g+j] = cur[3*g+j];
                end
                cur = nxt;
            end
            n = n - g;
        end
        return cur;
    endfunction

    function automatic logic [PW-1:0] cpa(input rows_t r);
        return r[0] + r[1];
    endfunction

    // CSA level reached at the output of middle stage k (k=0 is the PP stage).
    function automatic int unsigned bnd(input int unsigned k);
        int unsigned b;
        b = 0;
        if (STAGES > 2) b = (LV * k) / (STAGES - 2);
        return b;
    endfunction

    // ---------------- Booth partial products ----------------
    logic [EW-1:0]  xe;
    logic [EW:0]    yb;
    logic [EW-1:0]  pp [NPP];
    logic [NPP-1:0] neg;
    rows_t          lvl0;

    assign xe = {{2{in_signed & in_x[WIDTH-1]}}, in_x};
    assign yb = {{2{in_signed & in_y[WIDTH-1]}}, in_y, 1'b0};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        booth_pp_gen #(.EW(EW)) u_pp (
            .x   (xe),
            .sel (yb[2*i+2 -: 3]),
            .pp  (pp[i]),
            .neg (neg[i])
        );
    end

    always_comb begin
        lvl0 = '0;
        for (int unsigned i = 0; i < NPP; i++) begin
            lvl0[i] = {{(PW-EW){pp[i][EW-1]}}, pp[i]} << (2 * i);
            lvl0[MAXR-1][2*i] = neg[i];
        end
    end

    // ---------------- valid chain / handshake ----------------
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] up_v;

    // Stage k may load iff some stage at or after k is empty or the output
    // drains; written flat rather than as a ripple chain.
    always_comb begin
        en = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            en[k] = out_ready | (|(~v & (ONES << k)));
        end
    end

    assign up_v      = STAGES'({v, in_valid});
    assign in_ready  = en[0];
    assign out_valid = v[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (en[k]) v[k] <= up_v[k];
            end
        end
    end

    // ---------------- datapath registers ----------------
    if (STAGES == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                out_result <= '0;
            end else if (en[0] & in_valid) begin
                out_result <= cpa(csa_reduce(lvl0, 0, LV));
            end
        end
    end else begin : g_multi
        rows_t d    [STAGES-1];
        rows_t d_in [STAGES-1];

        assign d_in[0] = lvl0;
        for (genvar k = 1; k < STAGES - 1; k++) begin : g_mid
            assign d_in[k] = csa_reduce(d[k-1], bnd(k - 1), bnd(k));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k < STAGES - 1; k++) d[k] <= '0;
                out_result <= '0;
            end else begin
                for (int unsigned k = 0; k < STAGES - 1; k++) begin
                    if (en[k] & up_v[k]) d[k] <= d_in[k];
                end
                if (en[STAGES-1] & v[STAGES-2]) begin
                    out_result <= cpa(csa_reduce(d[STAGES-2], bnd(STAGES - 2), LV));
                end
            end
        end
    end

`ifdef BOOTH_MUL_TAG_EN
    logic [TAG_W-1:0] tag_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) tag_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (en[k] & up_v[k]) tag_q[k] <= (k == 0) ? in_tag : tag_q[k-1];
            end
        end
    end

    assign out_tag = tag_q[STAGES-1];
`endif

endmodule
